// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises rv32i fetch and load/store onto one memory port; MEM_PORT_ARBITER_TIMEOUT_EN adds an ack watchdog.
// Latency: 1 cycle request->strobe, 1 cycle ack->rdy; a losing requester just holds its level request until granted.
module mem_port_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int DATA_PRIORITY  = 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_rdy,
  input  logic                d_re,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_rrdy,
  output logic                d_wrdy,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_re,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ack,
  output logic [1:0]          grant,
  output logic                timeout_err
);
  localparam int BE_W = DATA_W / 8;
  localparam logic [DATA_W-1:0] TMO_DATA = DATA_W'(32'hDEAD_BEEF);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, RESP} state_t;

  state_t              state, state_nxt;
  logic                cmd_d;
  logic                cmd_we;
  logic [ADDR_W-1:0]   cmd_addr;
  logic [BE_W-1:0]     cmd_be;
  logic [DATA_W-1:0]   cmd_wdata;
  logic                d_req, pick_d, granted, tmo, done;
  logic [DATA_W-1:0]   rd_val;

  assign d_req   = d_re | d_we;
  assign pick_d  = d_req & ((DATA_PRIORITY != 0) | ~if_req);
  assign granted = (state == GNT_I) | (state == GNT_D);
  assign done    = granted & (mem_ack | tmo);
  // A real ack always wins over a watchdog expiry in the same cycle.
  assign rd_val  = mem_ack ? mem_rdata : TMO_DATA;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:         if (pick_d)      state_nxt = GNT_D;
                    else if (if_req) state_nxt = GNT_I;
      GNT_I, GNT_D: if (done)        state_nxt = RESP;
      RESP:                          state_nxt = IDLE;
      default:                       state_nxt = IDLE;
    endcase
  end

  // Command is frozen at grant time so requester inputs may wander while granted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd_d     <= 1'b0;
      cmd_we    <= 1'b0;
      cmd_addr  <= '0;
      cmd_be    <= '0;
      cmd_wdata <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      if (state == IDLE && (d_req || if_req)) begin
        cmd_d <= pick_d;
        if (pick_d) begin
          cmd_addr  <= d_addr;
          cmd_we    <= d_we;
          cmd_be    <= d_we ? d_be : '1;
          cmd_wdata <= d_wdata;
        end else begin
          cmd_addr  <= if_addr;
          cmd_we    <= 1'b0;
          cmd_be    <= '1;
        end
      end
      if (done && !cmd_we) begin
        if (cmd_d) d_rdata  <= rd_val;
        else       if_rdata <= rd_val;
      end
    end
  end

`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
  localparam int TMO_MAX = (TIMEOUT_CYCLES < 1) ? 1 : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(TMO_MAX + 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             tmo_err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt  <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      if (state == IDLE)           wait_cnt <= '0;
      else if (granted && !mem_ack) wait_cnt <= wait_cnt + 1'b1;
      if (tmo) tmo_err_q <= 1'b1;
    end
  end

  // Fires on the cycle whose missing ack would take the count to the limit.
  assign tmo         = granted & ~mem_ack & (wait_cnt == CNT_W'(TMO_MAX - 1));
  assign timeout_err = tmo_err_q;
`else
  assign tmo         = 1'b0;
  assign timeout_err = (TIMEOUT_CYCLES < 0);
`endif

  assign mem_addr  = cmd_addr;
  assign mem_be    = cmd_be;
  assign mem_wdata = cmd_wdata;
  assign mem_re    = granted & ~cmd_we;
  assign mem_we    = granted & cmd_we;
  assign grant     = {state == GNT_D, state == GNT_I};
  assign if_rdy    = (state == RESP) & ~cmd_d;
  assign d_rrdy    = (state == RESP) & cmd_d & ~cmd_we;
  assign d_wrdy    = (state == RESP) & cmd_d & cmd_we;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboarded random + directed bench for mem_port_arbiter; a second instance covers DATA_PRIORITY = 0.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        if_req, if_rdy;
  logic [31:0] if_addr, if_rdata;
  logic        d_re, d_we, d_rrdy, d_wrdy;
  logic [3:0]  d_be;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_re, mem_we, mem_ack;
  logic [3:0]  mem_be;
  logic [1:0]  grant;
  logic        timeout_err;

  logic        b_if_req, b_d_re, b_if_rdy, b_d_rrdy, b_d_wrdy, b_re, b_we, b_ack, b_tmo;
  logic [31:0] b_if_rdata, b_d_rdata, b_maddr, b_mwdata;
  logic [3:0]  b_mbe;
  logic [1:0]  b_grant;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .DATA_PRIORITY(1), .TIMEOUT_CYCLES(8)) u_dut (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_rdy(if_rdy),
    .d_re(d_re), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata),
    .d_rrdy(d_rrdy), .d_wrdy(d_wrdy), .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .grant(grant), .timeout_err(timeout_err));

  // Zero-wait memory: ack combinationally with the strobe.
  assign b_ack = b_re | b_we;
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .DATA_PRIORITY(0), .TIMEOUT_CYCLES(8)) u_dut_ipri (
    .clk(clk), .rst(rst), .if_req(b_if_req), .if_addr(32'h200), .if_rdata(b_if_rdata), .if_rdy(b_if_rdy),
    .d_re(b_d_re), .d_we(1'b0), .d_be(4'h0), .d_addr(32'h80), .d_wdata(32'h0), .d_rdata(b_d_rdata),
    .d_rrdy(b_d_rrdy), .d_wrdy(b_d_wrdy), .mem_addr(b_maddr), .mem_re(b_re), .mem_we(b_we),
    .mem_be(b_mbe), .mem_wdata(b_mwdata), .mem_rdata(32'h0BAD_F00D), .mem_ack(b_ack),
    .grant(b_grant), .timeout_err(b_tmo));

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s at %0t", nm, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct packed { logic wr; logic [31:0] data; } exp_t;
  exp_t        exp_d_q[$];
  logic [31:0] exp_if_q[$];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] mem_arr [logic [31:0]];
  logic [31:0] last_d, last_if;

  function automatic logic [31:0] init_word(input logic [31:0] widx);
    return (widx * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a >> 2) ? ref_mem[a >> 2] : init_word(a >> 2);
  endfunction

  function automatic void ref_wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
    logic [31:0] m;
    m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    ref_mem[a >> 2] = (ref_rd(a) & ~m) | (wd & m);
  endfunction

  task automatic push_fetch(input logic [31:0] a);
    last_if = ref_rd(a);
    exp_if_q.push_back(last_if);
  endtask

  // Both strobes together count as a write; writes leave d_rdata at its previous value.
  task automatic push_data(input logic we, input logic [3:0] be, input logic [31:0] a, input logic [31:0] wd);
    exp_t e;
    if (we) begin
      ref_wr(a, be, wd);
      e.wr = 1'b1;
    end else begin
      last_d = ref_rd(a);
      e.wr = 1'b0;
    end
    e.data = last_d;
    exp_d_q.push_back(e);
  endtask

  // ---------------- memory model ----------------
  int          force_dly = -1;
  bit          spurious_ack = 1'b0;
  int          mdly, mcnt;
  bit          mbusy;
  logic [31:0] mm_w;

  function automatic logic [31:0] mm_rd(input logic [31:0] a);
    return mem_arr.exists(a >> 2) ? mem_arr[a >> 2] : init_word(a >> 2);
  endfunction

  always @(negedge clk) begin
    mem_ack   = 1'b0;
    mem_rdata = $urandom;
    if (!rst) begin
      mbusy = 1'b0;
    end else if (mem_re || mem_we) begin
      chk("mem_strobe_excl", 32'(mem_re & mem_we), 32'd0);
      if (mem_re) chk("mem_be_read", 32'(mem_be), 32'hF);
      if (!mbusy) begin
        mbusy = 1'b1;
        mcnt  = 0;
        mdly  = (force_dly < 0) ? int'($urandom_range(0, 3)) : force_dly;
      end
      if (mcnt == mdly) begin
        mem_ack = 1'b1;
        mbusy   = 1'b0;
        if (mem_we) begin
          mm_w = mm_rd(mem_addr);
          for (int b = 0; b < 4; b++) if (mem_be[b]) mm_w[8*b +: 8] = mem_wdata[8*b +: 8];
          mem_arr[mem_addr >> 2] = mm_w;
        end else begin
          mem_rdata = mm_rd(mem_addr);
        end
      end else begin
        mcnt++;
      end
    end else begin
      mbusy = 1'b0;
      if (spurious_ack) begin
        mem_ack      = 1'b1;
        spurious_ack = 1'b0;
      end
    end
  end

  // ---------------- monitor ----------------
  exp_t mon_e;
  always @(negedge clk) begin
    if (rst) begin
      if (if_rdy || d_rrdy || d_wrdy)
        chk("rdy_onehot", 32'($countones({if_rdy, d_rrdy, d_wrdy})), 32'd1);
      if (if_rdy) begin
        if (exp_if_q.size() == 0) fail("if_rdy_unexpected");
        else chk("if_rdata", if_rdata, exp_if_q.pop_front());
      end
      if (d_rrdy || d_wrdy) begin
        if (exp_d_q.size() == 0) fail("d_rdy_unexpected");
        else begin
          mon_e = exp_d_q.pop_front();
          chk("d_kind_wr", 32'(d_wrdy), 32'(mon_e.wr));
          chk("d_rdata", d_rdata, mon_e.data);
        end
      end
    end
  end

  // ---------------- requester drivers ----------------
  task automatic fetch_txn(input logic [31:0] a);
    bit done = 1'b0;
    bit scr  = 1'b0;
    @(negedge clk);
    if_addr = a;
    if_req  = 1'b1;
    push_fetch(a);
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk);
      if (if_rdy) begin
        if_req = 1'b0;
        done   = 1'b1;
      end else if (grant == 2'b01 && !scr) begin
        if_addr = $urandom;
        scr     = 1'b1;
      end
    end
    if (!done) begin
      fail("fetch_rdy_timeout");
      if_req = 1'b0;
    end
  endtask

  task automatic data_txn(input logic re, input logic we, input logic [3:0] be,
                          input logic [31:0] a, input logic [31:0] wd);
    bit done = 1'b0;
    bit scr  = 1'b0;
    @(negedge clk);
    d_addr  = a;
    d_be    = be;
    d_wdata = wd;
    d_re    = re;
    d_we    = we;
    push_data(we, be, a, wd);
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk);
      if (d_rrdy || d_wrdy) begin
        d_re = 1'b0;
        d_we = 1'b0;
        done = 1'b1;
      end else if (grant == 2'b10 && !scr) begin
        d_addr  = $urandom;
        d_wdata = $urandom;
        d_be    = 4'($urandom);
        scr     = 1'b1;
      end
    end
    if (!done) begin
      fail("data_rdy_timeout");
      d_re = 1'b0;
      d_we = 1'b0;
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_grant"}, 32'(grant), 32'd0);
    chk({tag, "_mem_re"}, 32'(mem_re), 32'd0);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_rdys"}, 32'({if_rdy, d_rrdy, d_wrdy}), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  int  scnt;
  bit  seen;

  initial begin
    rst = 1'b0; if_req = 1'b0; if_addr = '0; d_re = 1'b0; d_we = 1'b0;
    d_be = '0; d_addr = '0; d_wdata = '0; b_if_req = 1'b0; b_d_re = 1'b0;
    last_d = '0; last_if = '0;
    mem_arr[32'h100 >> 2] = 32'h0010_0093;
    ref_mem[32'h100 >> 2] = 32'h0010_0093;

    repeat (3) @(posedge clk);
    #1;
    check_idle("rst_in");
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_be", 32'(mem_be), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    chk("rst_timeout_err", 32'(timeout_err), 32'd0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    check_idle("rst_out");

    // Zero-wait fetch: strobe at cycle 1, if_rdy at cycle 2.
    @(negedge clk);
    force_dly = 0;
    if_addr = 32'h100; if_req = 1'b1;
    push_fetch(32'h100);
    @(posedge clk); #1;
    chk("f_grant", 32'(grant), 32'd1);
    chk("f_mem_re", 32'(mem_re), 32'd1);
    chk("f_mem_addr", mem_addr, 32'h100);
    chk("f_mem_be", 32'(mem_be), 32'hF);
    @(posedge clk); #1;
    chk("f_if_rdy", 32'(if_rdy), 32'd1);
    chk("f_if_rdata", if_rdata, 32'h0010_0093);
    chk("f_strobe_drop", 32'(mem_re), 32'd0);
    if_req = 1'b0;
    @(posedge clk);

    // Write with 3-cycle ack; inputs scrambled after grant must not leak through.
    @(negedge clk);
    force_dly = 2;
    d_we = 1'b1; d_addr = 32'h40; d_be = 4'h3; d_wdata = 32'h1234_ABCD;
    push_data(1'b1, 4'h3, 32'h40, 32'h1234_ABCD);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("w_mem_we", 32'(mem_we), 32'd1);
      chk("w_mem_be", 32'(mem_be), 32'h3);
      chk("w_mem_wdata", mem_wdata, 32'h1234_ABCD);
      chk("w_mem_addr", mem_addr, 32'h40);
      chk("w_grant", 32'(grant), 32'd2);
      chk("w_no_rdy", 32'(d_wrdy), 32'd0);
      if (i == 0) begin d_wdata = '1; d_be = 4'hF; d_addr = 32'h7C; end
    end
    @(posedge clk); #1;
    chk("w_d_wrdy", 32'(d_wrdy), 32'd1);
    chk("w_strobe_drop", 32'(mem_we), 32'd0);
    d_we = 1'b0;
    @(posedge clk);

    // Simultaneous requests: data first on u_dut, fetch first on u_dut_ipri.
    @(negedge clk);
    force_dly = 0;
    if_addr = 32'h104; if_req = 1'b1;
    d_addr = 32'h40; d_re = 1'b1;
    b_if_req = 1'b1; b_d_re = 1'b1;
    push_data(1'b0, 4'h0, 32'h40, 32'h0);
    push_fetch(32'h104);
    @(posedge clk); #1;
    chk("p_grant_c1", 32'(grant), 32'd2);
    chk("pb_grant_c1", 32'(b_grant), 32'd1);
    @(posedge clk); #1;
    chk("p_d_rrdy_c2", 32'(d_rrdy), 32'd1);
    chk("pb_if_rdy_c2", 32'(b_if_rdy), 32'd1);
    chk("pb_if_rdata", b_if_rdata, 32'h0BAD_F00D);
    d_re = 1'b0; b_if_req = 1'b0;
    @(posedge clk); #1;
    chk("p_grant_c3", 32'(grant), 32'd0);
    chk("pb_grant_c3", 32'(b_grant), 32'd0);
    @(posedge clk); #1;
    chk("p_grant_c4", 32'(grant), 32'd1);
    chk("pb_grant_c4", 32'(b_grant), 32'd2);
    @(posedge clk); #1;
    chk("p_if_rdy_c5", 32'(if_rdy), 32'd1);
    chk("pb_d_rrdy_c5", 32'(b_d_rrdy), 32'd1);
    if_req = 1'b0; b_d_re = 1'b0;

    // Randomised traffic on disjoint fetch (0x100..) and data (0x40..) regions.
    force_dly = -1;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          fetch_txn(32'h100 + ($urandom_range(0, 63) << 2));
        end
      end
      begin
        logic [1:0] op;
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          op = 2'($urandom_range(0, 3));
          data_txn(op != 2'd1 && op != 2'd2, op != 2'd0, 4'($urandom),
                   32'h40 + ($urandom_range(0, 15) << 2), $urandom);
        end
      end
    join
    @(posedge clk);

    // Reset mid-read aborts at once.
    @(negedge clk);
    force_dly = 5;
    d_re = 1'b1; d_addr = 32'h48;
    @(posedge clk); #1;
    chk("ra_grant", 32'(grant), 32'd2);
    @(posedge clk); @(posedge clk); #1;
    chk("ra_mem_re_pre", 32'(mem_re), 32'd1);
    rst = 1'b0;
    #1;
    check_idle("ra_async");
    chk("ra_d_rdata", d_rdata, 32'd0);
    d_re = 1'b0; last_d = '0; last_if = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_idle("ra_after");

    // Ack while idle must not complete anything.
    spurious_ack = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check_idle("sp_ack");
    end

    // No ack from memory.
    @(negedge clk);
    force_dly = 100000;
    d_re = 1'b1; d_addr = 32'h4C;
`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
    begin
      exp_t e;
      e.wr = 1'b0; e.data = 32'hDEAD_BEEF;
      exp_d_q.push_back(e);
      last_d = 32'hDEAD_BEEF;
    end
`endif
    scnt = 0; seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(posedge clk); #1;
      if (mem_re) scnt++;
      if (d_rrdy) begin seen = 1'b1; d_re = 1'b0; end
    end
`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
    chk("tmo_rdy_seen", 32'(seen), 32'd1);
    chk("tmo_strobe_cycles", 32'(scnt), 32'd8);
    chk("tmo_d_rdata", d_rdata, 32'hDEAD_BEEF);
    chk("tmo_err_set", 32'(timeout_err), 32'd1);
    d_re = 1'b0;
    force_dly = -1;
    data_txn(1'b1, 1'b0, 4'h0, 32'h40, 32'h0);
    @(posedge clk); #1;
    chk("tmo_err_sticky", 32'(timeout_err), 32'd1);
`else
    chk("noack_rdy_seen", 32'(seen), 32'd0);
    chk("noack_strobe_cycles", 32'(scnt), 32'd40);
    chk("noack_timeout_err", 32'(timeout_err), 32'd0);
    d_re = 1'b0;
    @(negedge clk) rst = 1'b0;
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    check_idle("noack_recover");
`endif

    repeat (3) @(posedge clk);
    chk("if_queue_drained", 32'(exp_if_q.size()), 32'd0);
    chk("d_queue_drained", 32'(exp_d_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_time_limit reached at %0t", $time);
    $fatal(1, "time limit");
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the rv32i core's instruction-fetch port and its data load/store port.
- Sits between riscv_rv32i and the memory model or SRAM wrapper.
- Serialises accesses with a small grant FSM, registers the memory-side command, and returns read data and ready pulses to the requester that owns the grant.

Parameters:
- ADDR_W, 32, address width on all ports.
- DATA_W, 32, data width; byte-enable width is DATA_W/8.
- DATA_PRIORITY, 1, 1: data port wins simultaneous requests; 0: instruction port wins.
- TIMEOUT_CYCLES, 255, ack watchdog limit (used only with the optional feature).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low.
- if_req  in  1  instruction fetch request (level).
- if_addr  in  ADDR_W  fetch address.
- if_rdata  out  DATA_W  fetched word.
- if_rdy  out  1  one-cycle fetch-complete pulse.
- d_re  in  1  data read request (level).
- d_we  in  1  data write request (level).
- d_be  in  DATA_W/8  write byte enables.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  write data.
- d_rdata  out  DATA_W  load data.
- d_rrdy  out  1  one-cycle read-complete pulse.
- d_wrdy  out  1  one-cycle write-complete pulse.
- mem_addr  out  ADDR_W  memory address.
- mem_re  out  1  memory read strobe.
- mem_we  out  1  memory write strobe.
- mem_be  out  DATA_W/8  memory byte enables.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid with mem_ack.
- mem_ack  in  1  memory completion pulse.
- grant  out  2  01 = instruction owner, 10 = data owner, 00 = idle.
- timeout_err  out  1  sticky watchdog error (optional feature only; tied 0 otherwise).

Behaviour:
- Reset (rst low, asynchronous): state IDLE. grant, mem_re, mem_we, all rdy pulses and timeout_err are 0. mem_addr, mem_be, mem_wdata, if_rdata and d_rdata are 0.
- States: IDLE, GNT_I, GNT_D, RESP.
- IDLE:
  - If a data request (d_re|d_we) and if_req are both high, the winner follows DATA_PRIORITY.
  - On a grant, latch address, be, wdata and direction into registers and go to GNT_I or GNT_D on the next edge.
  - With no request, stay in IDLE.
- GNT_x:
  - mem_re/mem_we are held high from the registered command until mem_ack is sampled high.
  - On mem_ack: capture mem_rdata into if_rdata or d_rdata (read only), pulse the matching rdy in the next cycle, drop the strobes, and go to RESP.
- RESP:
  - Exactly one of if_rdy/d_rrdy/d_wrdy is high for this single cycle. Then return to IDLE.
  - Requests are ignored in RESP. The requester must deassert on the edge where it samples rdy high.
- Latency: request seen at edge 0 gives the strobe at cycle 1. If mem_ack arrives at cycle k, rdy is high at cycle k+1. Minimum round trip with a zero-wait memory (ack at cycle 1) is 2 cycles request-to-rdy.
- d_re and d_we both high: treated as a write (mem_be = d_be). The read is dropped and no d_rrdy is issued.
- mem_be is 4'hF for all reads. d_be = 0 on a write is forwarded unchanged and still completes.
- mem_ack while in IDLE or RESP is ignored.
- Requester inputs changing while granted have no effect; the command is registered at grant time.
- Asserting rst mid-transaction aborts immediately: strobes drop and no rdy is issued.
- Outputs rdata hold their last captured value until the next read completes.

Optional Feature:
- Macro: MEM_PORT_ARBITER_TIMEOUT_EN.
- When defined:
  - A wait counter clears on entering GNT_x and increments each GNT_x cycle without mem_ack.
  - When it reaches TIMEOUT_CYCLES, the arbiter drops the strobes and goes to RESP, issuing the owner's rdy with rdata forced to 32'hDEAD_BEEF (reads only).
  - It also sets timeout_err, which stays high until reset.
- When undefined: no counter is built, timeout_err is tied 0, and the arbiter waits for mem_ack indefinitely.

Test Plan:
- Reset low for 3 cycles, release → all outputs 0, grant = 00, no strobes.
- if_req, if_addr = 0x100; memory acks at cycle 1 with 0x00100093 → mem_re at cycle 1, if_rdy and if_rdata = 0x00100093 at cycle 2, grant = 01 during GNT_I.
- d_we, d_addr = 0x40, d_be = 4'h3, d_wdata = 0x1234ABCD, 3-cycle ack delay → mem_we held 3 cycles with mem_be = 3 and mem_wdata = 0x1234ABCD, single d_wrdy pulse.
- if_req and d_re asserted in the same cycle, DATA_PRIORITY = 1 → data serviced first (grant = 10). Fetch starts after RESP/IDLE and if_rdy follows; repeat with DATA_PRIORITY = 0 → order reversed.
- d_re, ack delay 5, rst pulled low at cycle 3 → mem_re drops asynchronously, no d_rrdy, state IDLE after release.
- With MEM_PORT_ARBITER_TIMEOUT_EN and TIMEOUT_CYCLES = 8, d_re and no ack → d_rrdy after timeout with d_rdata = 0xDEADBEEF and timeout_err = 1 sticky. Without the macro, no rdy ever fires.
